// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: frame FSM states,
// prefix scan codes and the event record carried through the event FIFO.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAR,
    STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_REL_PREFIX = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_evt_t;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_key_rx_fifo.sv
// First-word fall-through event FIFO; a push into a full FIFO without a
// simultaneous pop is dropped and latches a sticky overflow flag.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  ps2_evt_t din,
  input  logic     pop,
  output ps2_evt_t dout,
  output logic     full,
  output logic     empty,
  output logic     overflow
);

  localparam int AW = $clog2(DEPTH);

  ps2_evt_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW + 1)'(DEPTH));
  assign overflow = overflow_q;
  // Empty FIFO presents zeros rather than whatever stale entry the pointer hits.
  assign dout     = empty ? '0 : mem_q[rd_ptr_q];

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    do_pop     = pop && !empty;
    do_push    = push && (!full || do_pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || (push && !do_push);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW + 1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW + 1)'(1);
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by count_q alone, which keeps it plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronises kclk/kin, deframes parity-checked bytes,
// folds E0/F0 prefixes into key events and queues them. Define PS2_RX_TIMEOUT_EN for the frame watchdog.
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_US  = 2000
) (
  input  logic       clk50,
  input  logic       rst,
  input  logic       kclk,
  input  logic       kin,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_rel,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic       idle,
  output logic       overflow,
  output logic       frame_err
);

  logic [SYNC_STAGES-1:0] kclk_sync_q, kclk_sync_d;
  logic [SYNC_STAGES-1:0] kin_sync_q, kin_sync_d;
  logic                   kclk_prev_q;
  logic                   kclk_s, kin_s, fall;
  ps2_state_e             state_q, state_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   byte_valid_q, byte_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   ext_q, ext_d, rel_q, rel_d;
  logic                   tmo_hit;
  logic                   push;
  ps2_evt_t               push_evt, head_evt;
  logic                   fifo_full, fifo_empty;

  assign kclk_sync_d = {kclk_sync_q[SYNC_STAGES-2:0], kclk};
  assign kin_sync_d  = {kin_sync_q[SYNC_STAGES-2:0], kin};
  assign kclk_s      = kclk_sync_q[SYNC_STAGES-1];
  assign kin_s       = kin_sync_q[SYNC_STAGES-1];
  assign fall        = kclk_prev_q && !kclk_s;

  always_ff @(posedge clk50) begin
    if (rst) begin
      kclk_sync_q  <= '1;
      kin_sync_q   <= '1;
      kclk_prev_q  <= 1'b1;
      state_q      <= IDLE;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ext_q        <= 1'b0;
      rel_q        <= 1'b0;
    end else begin
      kclk_sync_q  <= kclk_sync_d;
      kin_sync_q   <= kin_sync_d;
      kclk_prev_q  <= kclk_s;
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      ext_q        <= ext_d;
      rel_q        <= rel_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (tmo_hit) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        IDLE: if (!kin_s) begin
          state_d  = DATA;
          bitcnt_d = '0;
        end
        DATA: begin
          shift_d  = {kin_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PAR;
        end
        PAR: begin
          par_d   = kin_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (kin_s && odd_parity_ok(shift_q, par_q)) byte_valid_d = 1'b1;
          else                                         frame_err_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    idle = (state_q == IDLE) && !ext_q && !rel_q;
  end

  // Prefix decoder: shift_q still holds the received byte while byte_valid_q is high.
  always_comb begin
    ext_d         = ext_q;
    rel_d         = rel_q;
    push          = 1'b0;
    push_evt.ext  = ext_q;
    push_evt.rel  = rel_q;
    push_evt.code = shift_q;
    if (frame_err_q) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end else if (byte_valid_q) begin
      if (shift_q == PS2_EXT_PREFIX)      ext_d = 1'b1;
      else if (shift_q == PS2_REL_PREFIX) rel_d = 1'b1;
      else begin
        push  = 1'b1;
        ext_d = 1'b0;
        rel_d = 1'b0;
      end
    end
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TMO_CYCLES = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int TMO_W      = $clog2(TMO_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = (state_q == IDLE || fall) ? '0 : tmo_cnt_q + TMO_W'(1);
  end

  always_ff @(posedge clk50) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end

  assign tmo_hit = (tmo_cnt_q == TMO_W'(TMO_CYCLES));
`else
  // Without the watchdog the timing parameters have no effect.
  localparam int unused_tmo_cfg = CLK_HZ / 1000000 * TIMEOUT_US;
  assign tmo_hit = 1'b0;
`endif

  ps2_evt_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk50),
    .rst     (rst),
    .push    (push),
    .din     (push_evt),
    .pop     (evt_ready),
    .dout    (head_evt),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .overflow(overflow)
  );

  assign evt_valid = !fifo_empty;
  assign evt_code  = head_evt.code;
  assign evt_ext   = head_evt.ext;
  assign evt_rel   = head_evt.rel;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Self-checking bench for ps2_key_rx: a PS/2 bus model drives frames, a
// scoreboard queue holds expected events and a consumer monitor pops them.
module tb_ps2_key_rx;
  import ps2_pkg::*;

  // One clk50 cycle stands for 1 us, so an 80 us bit is 80 cycles.
  localparam int CLK_HZ   = 1000000;
  localparam int HALF_BIT = 40;

  logic       clk50 = 1'b0;
  logic       rst = 1'b1;
  logic       kclk = 1'b1;
  logic       kin = 1'b1;
  logic       evt_ready = 1'b0;
  logic [7:0] evt_code;
  logic       evt_ext, evt_rel, evt_valid, idle, overflow, frame_err;

  ps2_key_rx #(
    .CLK_HZ     (CLK_HZ),
    .FIFO_DEPTH (8),
    .SYNC_STAGES(2),
    .TIMEOUT_US (2000)
  ) dut (
    .clk50    (clk50),
    .rst      (rst),
    .kclk     (kclk),
    .kin      (kin),
    .evt_code (evt_code),
    .evt_ext  (evt_ext),
    .evt_rel  (evt_rel),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .idle     (idle),
    .overflow (overflow),
    .frame_err(frame_err)
  );

  always #5 clk50 = ~clk50;

  int       n_tests = 0;
  int       n_fail = 0;
  int       ferr_cnt = 0;
  ps2_evt_t exp_q[$];

  typedef struct {
    logic [7:0] code;
    logic       bad_par;
    logic       has_evt;
    ps2_evt_t   evt;
    logic       exp_idle;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk50);
      #2;
    end
  endtask

  // kin changes while kclk rises; the receiver samples on the falling edge.
  task automatic send_bit(input logic b, input bit lat_chk);
    kin = b;
    tick(HALF_BIT);
    kclk = 1'b0;
    if (lat_chk) begin
      tick(3);
      check("latency_not_yet", evt_valid, 1'b0);
      tick(1);
      check("latency_evt_valid", evt_valid, 1'b1);
      tick(HALF_BIT - 4);
    end else begin
      tick(HALF_BIT);
    end
    kclk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par, input bit lat_chk);
    logic [10:0] f;
    f = {1'b1, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i], lat_chk && (i == 10));
    tick(10);
  endtask

  function automatic vec_t mk(input logic [7:0] code, input logic bad_par, input logic has_evt,
                              input logic ext, input logic rel, input logic exp_idle,
                              input int exp_ferr);
    vec_t v;
    v.code     = code;
    v.bad_par  = bad_par;
    v.has_evt  = has_evt;
    v.evt      = {ext, rel, code};
    v.exp_idle = exp_idle;
    v.exp_ferr = exp_ferr;
    return v;
  endfunction

  // Consumer side: count frame_err cycles and score every accepted event.
  always @(negedge clk50) begin
    ps2_evt_t e;
    if (frame_err) ferr_cnt++;
    if (!rst && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: got %0h, expected no event", {evt_ext, evt_rel, evt_code});
      end else begin
        e = exp_q.pop_front();
        check("event", {evt_ext, evt_rel, evt_code}, e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;

    vecs[0]  = mk(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    vecs[1]  = mk(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    vecs[2]  = mk(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    vecs[3]  = mk(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    vecs[4]  = mk(8'h74, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    vecs[5]  = mk(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    vecs[6]  = mk(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    vecs[7]  = mk(8'h74, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    vecs[8]  = mk(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    vecs[9]  = mk(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    vecs[10] = mk(8'h12, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    vecs[11] = mk(8'hE1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    vecs[12] = mk(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    vecs[13] = mk(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    vecs[14] = mk(8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    vecs[15] = mk(8'h2B, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0);

    tick(4);
    rst = 1'b0;
    tick(1);
    check("rst_evt_valid", evt_valid, 1'b0);
    check("rst_evt_code", evt_code, 8'h00);
    check("rst_evt_ext_rel", {evt_ext, evt_rel}, 2'b00);
    check("rst_overflow", overflow, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_idle", idle, 1'b1);

    // Make code with latency measured from the stop-bit fall.
    exp_q.push_back({1'b0, 1'b0, 8'h1C});
    send_frame(8'h1C, 1'b0, 1'b1);
    check("make_head", {evt_ext, evt_rel, evt_code}, {2'b00, 8'h1C});
    check("make_idle", idle, 1'b1);
    evt_ready = 1'b1;
    tick(3);
    check("make_drained", exp_q.size(), 0);
    check("make_empty", evt_valid, 1'b0);

    for (int i = 0; i < 16; i++) begin
      base = ferr_cnt;
      if (vecs[i].has_evt) exp_q.push_back(vecs[i].evt);
      send_frame(vecs[i].code, vecs[i].bad_par, 1'b0);
      check($sformatf("vec%0d_idle", i), idle, vecs[i].exp_idle);
      check($sformatf("vec%0d_frame_err", i), ferr_cnt - base, vecs[i].exp_ferr);
      check($sformatf("vec%0d_drained", i), exp_q.size(), 0);
    end

    // Overflow: ninth code is dropped, flag stays set after draining.
    evt_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back({2'b00, 8'(8'h10 + i)});
      send_frame(8'(8'h10 + i), 1'b0, 1'b0);
    end
    check("ovf_flag", overflow, 1'b1);
    check("ovf_head", {evt_valid, evt_code}, {1'b1, 8'h10});
    evt_ready = 1'b1;
    tick(12);
    check("ovf_drained", exp_q.size(), 0);
    check("ovf_empty", evt_valid, 1'b0);
    check("ovf_sticky", overflow, 1'b1);

    // Truncated frame: start bit plus three data bits, then kclk stays high.
    base = ferr_cnt;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    tick(1900);
    check("tmo_before_idle", idle, 1'b0);
    tick(1100);
`ifdef PS2_RX_TIMEOUT_EN
    check("tmo_frame_err", ferr_cnt - base, 1);
    check("tmo_idle", idle, 1'b1);
`else
    check("no_tmo_frame_err", ferr_cnt - base, 0);
    check("no_tmo_idle", idle, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
`endif
    exp_q.push_back({2'b00, 8'h29});
    send_frame(8'h29, 1'b0, 1'b0);
    check("after_tmo_drained", exp_q.size(), 0);

    // Reset mid-frame with a queued event and a pending E0 prefix.
    evt_ready = 1'b0;
    send_frame(8'h33, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    check("pre_rst_valid", evt_valid, 1'b1);
    check("pre_rst_idle", idle, 1'b0);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_evt", {evt_valid, evt_ext, evt_rel, evt_code}, 11'h000);
    check("mid_rst_flags", {overflow, frame_err, idle}, 3'b001);
    evt_ready = 1'b1;
    base = ferr_cnt;
    exp_q.push_back({2'b00, 8'h1C});
    send_frame(8'h1C, 1'b0, 1'b0);
    check("post_rst_drained", exp_q.size(), 0);
    check("post_rst_frame_err", ferr_cnt - base, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
